iob_split_reg: RTL and testbench
================================

# iob_split_reg

Registered, parametrised 1-to-N splitter for the native IOb bus: one master, N_SLAVES slaves, selected by an address bit field. Requests are registered before reaching the slave, and responses are registered before returning to the master, which cuts the combinational path through the CPU data and peripheral buses. Unmapped selects are answered with an error response, and stalled slaves can be aborted by an optional watchdog. It replaces the combinational split on the dbus and pbus paths of the SoC.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- N_SLAVES, 3, number of slaves (≥2)
- P_SLAVES, 31, MSB position of the select field; SEL_W=$clog2(N_SLAVES) bits, field addr[P_SLAVES -: SEL_W]
- ERR_DATA, 32'hDEADBEEF, rdata returned on error
- TIMEOUT, 1024, watchdog limit in cycles (used only with SPLIT_TIMEOUT_EN)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, asynchronous, active-low
- m_valid  in  1  master request valid; held high until m_ready
- m_addr  in  ADDR_W  master address
- m_wdata  in  DATA_W  write data
- m_wstrb  in  DATA_W/8  byte strobes; all zero means read
- m_rdata  out  DATA_W  response data
- m_ready  out  1  one-cycle response pulse
- m_err  out  1  qualifies m_ready: the response is an error
- s_valid  out  N_SLAVES  one-hot slave valid
- s_addr  out  ADDR_W  registered address, common to all slaves
- s_wdata  out  DATA_W  registered write data, common to all slaves
- s_wstrb  out  DATA_W/8  registered strobes, common to all slaves
- s_rdata  in  N_SLAVES*DATA_W  slave k at [k*DATA_W +: DATA_W]
- s_ready  in  N_SLAVES  slave response pulses
- err_count  out  8  saturating error counter

## Operation
- The FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - On m_valid, latch addr, wdata and wstrb, and compute sel.
  - If sel < N_SLAVES, set s_valid[sel] and go to BUSY.
  - Otherwise go to RESP with the error flag set and rdata=ERR_DATA.
- BUSY:
  - s_valid[sel] is held.
  - On s_ready[sel], capture s_rdata[sel], clear s_valid, and go to RESP with the error flag clear.
  - s_ready on non-selected slaves is ignored.
- RESP:
  - m_ready=1, m_rdata=captured data, m_err=flag.
  - Always go to IDLE next cycle.
  - m_valid sampled in RESP is ignored, because the master may still be holding it high.
- Every error response increments err_count, which saturates at 255.
- s_ready arriving in IDLE or RESP is ignored.

## Timing
- Reset values: state=IDLE, s_valid=0, m_ready=0, m_err=0, m_rdata=0, s_addr/s_wdata/s_wstrb=0, err_count=0, timer=0.
- Reset asserted mid-transaction aborts immediately. The slave sees s_valid fall with no handshake, and no response is produced.
- Nominal timing: m_valid high at cycle 0, s_valid at cycle 1, slave ready at cycle k≥1, m_ready at cycle k+1.
- Best case (zero-wait slave, ready in the same cycle as valid): m_ready at cycle 2.
- Unmapped select: m_ready with m_err at cycle 1.
- Back-to-back: the next request is accepted in the cycle after RESP. Throughput is one transaction per 3 cycles minimum.
- Every output is driven from a register. There is no combinational path from input to output.

## Configuration
- Macro: SPLIT_TIMEOUT_EN.
- Defined:
  - A timer clears on entry to BUSY and increments each BUSY cycle.
  - If the timer reaches TIMEOUT-1 without s_ready[sel]: clear s_valid, go to RESP with m_err=1 and rdata=ERR_DATA, and increment err_count.
  - s_ready arriving in the same cycle as the timeout wins, and the response is normal.
  - A late s_ready afterwards is ignored.
- Undefined: there is no timer logic. BUSY waits indefinitely, and TIMEOUT is unused.

## Structure
- Package iob_split_pkg holds:
  - the state encoding (IDLE=0, BUSY=1, RESP=2)
  - the default ERR_DATA constant
  - the err_count width constant (8)
  - a SEL_W helper function
- Sub-module iob_split_timer holds the watchdog counter. It has inputs clk, rst, clear and enable, and output expired. It is instantiated only under SPLIT_TIMEOUT_EN.

## Test plan
- Read from slave 1 with a zero-wait slave (N_SLAVES=3, P_SLAVES=31, addr=32'h4000_0010) -> s_valid=3'b010 at cycle 1, m_ready at cycle 2, m_rdata equals slave data, m_err=0.
- Write to slave 2 (addr=32'h8000_0004, wdata=32'h1234_5678, wstrb=4'hF) with ready after 5 wait cycles -> s_wdata/s_wstrb stable throughout BUSY, m_ready exactly 1 cycle after s_ready.
- Unmapped select (addr=32'hC000_0000) -> m_ready and m_err at cycle 1, m_rdata=32'hDEADBEEF, err_count=1, no s_valid bit ever set.
- Master holds m_valid through RESP and then issues a new request -> exactly one transaction per response, no duplicate s_valid.
- With SPLIT_TIMEOUT_EN and TIMEOUT=16, slave never ready -> s_valid drops and m_err=1 after 16 BUSY cycles. A later s_ready is ignored. s_ready on cycle 15 instead gives a normal response.
- rst asserted low while in BUSY -> all outputs return to reset values asynchronously, err_count=0, and the next request after release completes normally.

Source files
------------

// File: rtl/iob_split_pkg.sv
// Shared definitions for the registered IOb 1-to-N splitter.
package iob_split_pkg;

  // Splitter FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  // Data returned to the master on unmapped selects and watchdog aborts
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Width of the saturating error counter
  localparam int ERR_CNT_W = 8;

  // Number of address bits needed to select one of nSlaves slaves
  function automatic int sel_width(input int nSlaves);
    return (nSlaves > 1) ? $clog2(nSlaves) : 1;
  endfunction

endpackage

// File: rtl/iob_split_timer.sv
// Watchdog counter for the splitter: counts cycles while enabled and flags
// expiry when the count reaches TIMEOUT-1. Only used with SPLIT_TIMEOUT_EN.
module iob_split_timer
  import iob_split_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = (count_q == CNT_W'(TIMEOUT - 1));

  // Next count: clear has priority, then count up while enabled, holding at expiry
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/iob_split_reg.sv
// Registered 1-to-N splitter for the native IOb bus. Requests are registered
// towards the slaves and responses registered towards the master, so no
// combinational path crosses the block. Unmapped selects get an error reply.
// Optional watchdog abort of stalled slaves: define SPLIT_TIMEOUT_EN.
module iob_split_reg
  import iob_split_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              N_SLAVES = 3,
  parameter int              P_SLAVES = 31,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT,
  parameter int              TIMEOUT  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       m_valid,
  input  logic [ADDR_W-1:0]          m_addr,
  input  logic [DATA_W-1:0]          m_wdata,
  input  logic [DATA_W/8-1:0]        m_wstrb,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       m_ready,
  output logic                       m_err,
  output logic [N_SLAVES-1:0]        s_valid,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [DATA_W/8-1:0]        s_wstrb,
  input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]        s_ready,
  output logic [ERR_CNT_W-1:0]       err_count
);

  localparam int SEL_W = sel_width(N_SLAVES);

  state_e                 state_q, state_d;
  logic [N_SLAVES-1:0]    sValid_q, sValid_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [DATA_W/8-1:0]    wstrb_q, wstrb_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   ready_q, ready_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   errCnt_q, errCnt_d;

  logic [SEL_W-1:0]       sel;
  logic                   selHit;
  logic                   errInc;
  logic [DATA_W-1:0]      slaveData;
  logic                   timedOut;

`ifdef SPLIT_TIMEOUT_EN
  // Watchdog runs only in BUSY and is held clear otherwise, so it starts at
  // zero on every entry to BUSY
  iob_split_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != BUSY),
    .enable (state_q == BUSY),
    .expired(timedOut)
  );
`else
  assign timedOut = 1'b0;
  wire unused_timeout = (TIMEOUT == 0);
`endif

  // Response mux: the held one-hot valid selects which slave's data to capture
  always_comb begin
    slaveData = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sValid_q[k]) begin
        slaveData = s_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and registered-output logic; ready from unselected slaves is
  // masked off by the one-hot valid, and ready outside BUSY is never looked at
  always_comb begin
    state_d  = state_q;
    sValid_d = sValid_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    ready_d  = ready_q;
    err_d    = err_q;
    errCnt_d = errCnt_q;
    errInc   = 1'b0;
    sel      = m_addr[P_SLAVES -: SEL_W];
    selHit   = |(s_ready & sValid_q);

    case (state_q)
      IDLE: begin
        if (m_valid) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          wstrb_d = m_wstrb;
          if (int'(sel) < N_SLAVES) begin
            sValid_d = {{(N_SLAVES-1){1'b0}}, 1'b1} << sel;
            state_d  = BUSY;
          end else begin
            rdata_d = ERR_DATA;
            err_d   = 1'b1;
            ready_d = 1'b1;
            errInc  = 1'b1;
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        if (selHit) begin
          sValid_d = '0;
          rdata_d  = slaveData;
          err_d    = 1'b0;
          ready_d  = 1'b1;
          state_d  = RESP;
        end else if (timedOut) begin
          sValid_d = '0;
          rdata_d  = ERR_DATA;
          err_d    = 1'b1;
          ready_d  = 1'b1;
          errInc   = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        ready_d = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        sValid_d = '0;
        ready_d  = 1'b0;
        err_d    = 1'b0;
        state_d  = IDLE;
      end
    endcase

    if (errInc && (errCnt_q != {ERR_CNT_W{1'b1}})) begin
      errCnt_d = errCnt_q + 1'b1;
    end
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sValid_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      errCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sValid_q <= sValid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      errCnt_q <= errCnt_d;
    end
  end

  assign s_valid   = sValid_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_wstrb   = wstrb_q;
  assign m_rdata   = rdata_q;
  assign m_ready   = ready_q;
  assign m_err     = err_q;
  assign err_count = errCnt_q;

endmodule

// File: tb/tb_iob_split_reg.sv
// Scoreboard bench for iob_split_reg: directed transactions push the expected
// response, a monitor pops and compares on every m_ready pulse.
module tb_iob_split_reg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int N_SLAVES   = 3;
  localparam int TB_TIMEOUT = 16;

  logic                       clk;
  logic                       rst;
  logic                       m_valid;
  logic [ADDR_W-1:0]          m_addr;
  logic [DATA_W-1:0]          m_wdata;
  logic [DATA_W/8-1:0]        m_wstrb;
  logic [DATA_W-1:0]          m_rdata;
  logic                       m_ready;
  logic                       m_err;
  logic [N_SLAVES-1:0]        s_valid;
  logic [ADDR_W-1:0]          s_addr;
  logic [DATA_W-1:0]          s_wdata;
  logic [DATA_W/8-1:0]        s_wstrb;
  logic [N_SLAVES*DATA_W-1:0] s_rdata;
  logic [N_SLAVES-1:0]        s_ready;
  logic [7:0]                 err_count;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t expQ[$];
  int    totalChecks = 0;
  int    badChecks   = 0;
  int    expErr      = 0;

  iob_split_reg #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .N_SLAVES(N_SLAVES),
    .P_SLAVES(31),
    .ERR_DATA(32'hDEADBEEF),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_valid  (m_valid),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .m_err    (m_err),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .err_count(err_count)
  );

  // Fixed per-slave read data
  assign s_rdata = {32'hCCCC_2222, 32'hBBBB_1111, 32'hAAAA_0000};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected response
  always @(negedge clk) begin
    resp_t e;
    if (rst && m_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected m_ready", 64'd1, 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("m_rdata", m_rdata, e.data);
        checkOutput("m_err", m_err, e.err);
      end
    end
  end

  // One transaction; slave < 0 means unmapped, waitCycles < 0 means never ready.
  // m_valid is left high through RESP so the caller can go back-to-back.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int waitCycles,
                               input int slave, input logic [31:0] expData);
    resp_t       r;
    logic [2:0]  oneHot;
    int          busyLen;
    @(posedge clk); #1;
    m_valid = 1'b1;
    m_addr  = addr;
    m_wdata = wdata;
    m_wstrb = wstrb;
    s_ready = '0;
    if (slave < 0) begin
      r.data = 32'hDEADBEEF;
      r.err  = 1'b1;
      expQ.push_back(r);
      if (expErr < 255) expErr++;
      @(negedge clk);
      checkOutput("early m_ready", m_ready, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("err m_ready", m_ready, 1'b1);
      checkOutput("err s_valid", s_valid, 3'b000);
      checkOutput("err_count", err_count, expErr);
    end else begin
      oneHot  = 3'b001 << slave;
      busyLen = (waitCycles < 0) ? TB_TIMEOUT : waitCycles + 1;
      if (waitCycles < 0) begin
        r.data = 32'hDEADBEEF;
        r.err  = 1'b1;
        if (expErr < 255) expErr++;
      end else begin
        r.data = expData;
        r.err  = 1'b0;
      end
      expQ.push_back(r);
      @(negedge clk);
      checkOutput("idle s_valid", s_valid, 3'b000);
      checkOutput("idle m_ready", m_ready, 1'b0);
      for (int b = 0; b < busyLen; b++) begin
        @(posedge clk); #1;
        s_ready = (b == waitCycles) ? oneHot : ~oneHot;
        @(negedge clk);
        checkOutput("busy s_valid", s_valid, oneHot);
        checkOutput("busy s_addr", s_addr, addr);
        checkOutput("busy s_wdata", s_wdata, wdata);
        checkOutput("busy s_wstrb", s_wstrb, wstrb);
        checkOutput("busy m_ready", m_ready, 1'b0);
      end
      @(posedge clk); #1;
      s_ready = '0;
      @(negedge clk);
      checkOutput("resp m_ready", m_ready, 1'b1);
      checkOutput("resp s_valid", s_valid, 3'b000);
      checkOutput("resp err_count", err_count, expErr);
    end
  endtask

  // Master idle; stray slave ready pulses must not produce anything
  task automatic idleCycles(input int n);
    @(posedge clk); #1;
    m_valid = 1'b0;
    s_ready = '1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput("idle after s_valid", s_valid, 3'b000);
      checkOutput("idle after m_ready", m_ready, 1'b0);
    end
    s_ready = '0;
  endtask

  // Reset asserted while a request sits in BUSY: everything clears at once
  task automatic resetDuringBusy();
    @(posedge clk); #1;
    m_valid = 1'b1;
    m_addr  = 32'h0000_0020;
    m_wdata = 32'h5555_AAAA;
    m_wstrb = 4'hC;
    s_ready = '0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    checkOutput("pre-reset s_valid", s_valid, 3'b001);
    rst = 1'b0;
    #1;
    checkOutput("rst s_valid", s_valid, 3'b000);
    checkOutput("rst m_ready", m_ready, 1'b0);
    checkOutput("rst m_err", m_err, 1'b0);
    checkOutput("rst m_rdata", m_rdata, 32'h0);
    checkOutput("rst s_addr", s_addr, 32'h0);
    checkOutput("rst s_wdata", s_wdata, 32'h0);
    checkOutput("rst s_wstrb", s_wstrb, 4'h0);
    checkOutput("rst err_count", err_count, 8'd0);
    m_valid = 1'b0;
    expErr  = 0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    m_valid = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_ready = '0;
    #12;
    checkOutput("reset s_valid", s_valid, 3'b000);
    checkOutput("reset m_ready", m_ready, 1'b0);
    checkOutput("reset m_rdata", m_rdata, 32'h0);
    checkOutput("reset err_count", err_count, 8'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Zero-wait read from slave 1
    applyStimulus(32'h4000_0010, 32'h0, 4'h0, 0, 1, 32'hBBBB_1111);
    idleCycles(2);
    // Write to slave 2 with 5 wait cycles
    applyStimulus(32'h8000_0004, 32'h1234_5678, 4'hF, 5, 2, 32'hCCCC_2222);
    idleCycles(1);
    // Unmapped select
    applyStimulus(32'hC000_0000, 32'h0, 4'h0, 0, -1, 32'h0);
    idleCycles(1);
    // m_valid held through RESP, then back-to-back requests
    applyStimulus(32'h0000_0100, 32'hCAFE_0001, 4'h3, 2, 0, 32'hAAAA_0000);
    applyStimulus(32'h4000_0200, 32'h0, 4'h0, 1, 1, 32'hBBBB_1111);
    applyStimulus(32'hC000_0004, 32'h0, 4'h0, 0, -1, 32'h0);
    applyStimulus(32'h8000_0008, 32'h0BAD_F00D, 4'h1, 15, 2, 32'hCCCC_2222);
    idleCycles(3);
`ifdef SPLIT_TIMEOUT_EN
    // Slave never answers: watchdog aborts, late ready ignored
    applyStimulus(32'h0000_0004, 32'h0, 4'h0, -1, 0, 32'h0);
    idleCycles(3);
`endif
    // Error counter saturation
    for (int i = 0; i < 256; i++) begin
      applyStimulus(32'hC000_1234, 32'h0, 4'h0, 0, -1, 32'h0);
    end
    idleCycles(1);
    checkOutput("err_count saturated", err_count, 8'd255);
    // Reset mid-transaction, then a normal request
    resetDuringBusy();
    applyStimulus(32'h4000_0000, 32'h0000_0001, 4'h1, 3, 1, 32'hBBBB_1111);
    idleCycles(2);

    checkOutput("pending responses", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
